// File: rtl/piano_pkg.sv
// Shared constants and types for the piano voice scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piano_pkg;

   localparam int NUM_KEYS = 48;
   localparam int KEY_W    = 6;

   // Index one past the last key marks a voice that has no key.
   localparam logic [KEY_W-1:0] KEY_NONE = KEY_W'(NUM_KEYS);

   typedef enum logic [1:0] {
      S_SCAN  = 2'd0,
      S_ALLOC = 2'd1,
      S_FREE  = 2'd2
   } state_t;

   typedef struct packed {
      logic             on;
      logic [KEY_W-1:0] key;
   } voice_t;

   // Scan pointer successor: walk 0..NUM_KEYS-1, then wrap to 0.
   function automatic logic [KEY_W-1:0] next_key_idx(input logic [KEY_W-1:0] idx);
      if (idx == KEY_W'(NUM_KEYS - 1)) begin
         return '0;
      end
      return idx + KEY_W'(1);
   endfunction

endpackage

// File: rtl/voice_allocator_lru_tracker.sv
// LRU rank keeper: one rank per voice, always a permutation; rank NUM_VOICES-1 is the victim.
// Latency: touch/clear take effect on the next edge; victim_idx is combinational from the ranks.
// Backpressure: none; a touch is accepted every cycle.
module lru_tracker #(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             touch,
   input  logic [IDX_W-1:0] touch_idx,
   input  logic             clear,
   output logic [IDX_W-1:0] victim_idx
);

   logic [IDX_W-1:0] rank [NUM_VOICES];
   logic [IDX_W-1:0] touched_rank;

   assign touched_rank = rank[touch_idx];

   // Rank update: touched voice becomes newest, everything newer than it ages by one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            rank[v] <= IDX_W'(v);
         end
      end else if (clear) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            rank[v] <= IDX_W'(v);
         end
      end else if (touch) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (IDX_W'(v) == touch_idx) begin
               rank[v] <= '0;
            end else if (rank[v] < touched_rank) begin
               rank[v] <= rank[v] + IDX_W'(1);
            end
         end
      end
   end

   // Victim lookup: the voice holding the oldest rank.
   always_comb begin
      victim_idx = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (rank[v] == IDX_W'(NUM_VOICES - 1)) begin
            victim_idx = IDX_W'(v);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans one key per cycle, maps held keys onto NUM_VOICES tone generators.
// Latency: outputs registered, change visible the cycle after S_ALLOC/S_FREE; press-to-voice <= NUM_KEYS+1 cycles.
// Backpressure: enable=0 freezes the scan (voices hold); clear releases all voices. Option macro: VOICE_ALLOC_STEAL_EN.
module voice_allocator
   import piano_pkg::*;
#(
   parameter int NUM_VOICES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KEYS-1:0]         keys,
   input  logic                        enable,
   input  logic                        clear,
   output logic [NUM_VOICES*KEY_W-1:0] voice_key,
   output logic [NUM_VOICES-1:0]       voice_on,
   output logic                        voice_upd,
   output logic                        dropped
);

   localparam int VIDX_W = $clog2(NUM_VOICES);

   state_t              state;
   state_t              state_nxt;
   logic [KEY_W-1:0]    scan_idx;
   logic                idx_adv;
   logic [NUM_KEYS-1:0] prev;

   voice_t              voices     [NUM_VOICES];
   voice_t              voices_nxt [NUM_VOICES];
   logic                upd_nxt;
   logic                drop_nxt;

   logic                key_now;
   logic                key_prev;
   logic                press;
   logic                release_evt;

   logic [NUM_VOICES-1:0] hit_vec;
   logic                  hit_any;
   logic                  any_on;
   logic                  free_found;
   logic [VIDX_W-1:0]     free_idx;

`ifdef VOICE_ALLOC_STEAL_EN
   logic                  touch;
   logic [VIDX_W-1:0]     touch_idx;
   logic [VIDX_W-1:0]     victim_idx;

   // Ranks only influence which voice gets stolen, so they exist only when stealing does.
   lru_tracker #(
      .NUM_VOICES (NUM_VOICES),
      .IDX_W      (VIDX_W)
   ) u_lru (
      .clk        (clk),
      .reset      (reset),
      .touch      (touch),
      .touch_idx  (touch_idx),
      .clear      (clear),
      .victim_idx (victim_idx)
   );
`endif

   assign key_now     = keys[scan_idx];
   assign key_prev    = prev[scan_idx];
   assign press       = key_now & ~key_prev;
   assign release_evt = ~key_now & key_prev;

   // Voice lookup: who already holds the scanned key, and the lowest-index idle voice.
   always_comb begin
      hit_vec    = '0;
      any_on     = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         hit_vec[v] = voices[v].on && (voices[v].key == scan_idx);
         any_on     = any_on | voices[v].on;
      end
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!voices[v].on) begin
            free_found = 1'b1;
            free_idx   = VIDX_W'(v);
         end
      end
   end

   assign hit_any = |hit_vec;

   // Next-state logic: an event parks the pointer for one service cycle, otherwise it advances.
   always_comb begin
      state_nxt = state;
      idx_adv   = 1'b0;
      case (state)
         S_SCAN: begin
            if (enable) begin
               if (press) begin
                  state_nxt = S_ALLOC;
               end else if (release_evt) begin
                  state_nxt = S_FREE;
               end else begin
                  idx_adv = 1'b1;
               end
            end
         end
         S_ALLOC, S_FREE: begin
            // Service cycles always finish, even if enable dropped meanwhile.
            state_nxt = S_SCAN;
            idx_adv   = 1'b1;
         end
         default: begin
            state_nxt = S_SCAN;
         end
      endcase
   end

   // Voice table update for the current service cycle; clear overrides everything.
   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         voices_nxt[v] = voices[v];
      end
      upd_nxt  = 1'b0;
      drop_nxt = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
      touch     = 1'b0;
      touch_idx = '0;
`endif
      if (clear) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            voices_nxt[v] = '{on: 1'b0, key: KEY_NONE};
         end
         upd_nxt = any_on;
`ifdef VOICE_ALLOC_STEAL_EN
         touch   = 1'b0;
`endif
      end else if (state == S_ALLOC) begin
         // A key that already owns a voice keeps it; nothing changes.
         if (!hit_any) begin
            if (free_found) begin
               voices_nxt[free_idx] = '{on: 1'b1, key: scan_idx};
               upd_nxt              = 1'b1;
`ifdef VOICE_ALLOC_STEAL_EN
               touch                = 1'b1;
               touch_idx            = free_idx;
`endif
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
               voices_nxt[victim_idx] = '{on: 1'b1, key: scan_idx};
               upd_nxt                = 1'b1;
               touch                  = 1'b1;
               touch_idx              = victim_idx;
`else
               drop_nxt               = 1'b1;
`endif
            end
         end
      end else if (state == S_FREE) begin
         // A stolen key finds no voice here and its release is silent.
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (hit_vec[v]) begin
               voices_nxt[v] = '{on: 1'b0, key: KEY_NONE};
               upd_nxt       = 1'b1;
            end
         end
      end
   end

   // Scan pointer, key snapshot and FSM state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_SCAN;
         scan_idx <= '0;
         prev     <= '0;
      end else if (clear) begin
         // Snapshot current levels so keys held across clear need a fresh press.
         state    <= S_SCAN;
         scan_idx <= '0;
         prev     <= keys;
      end else begin
         state <= state_nxt;
         if (idx_adv) begin
            scan_idx <= next_key_idx(scan_idx);
         end
         // Snapshot follows the level seen at detection, even for dropped presses.
         if (state == S_ALLOC) begin
            prev[scan_idx] <= 1'b1;
         end else if (state == S_FREE) begin
            prev[scan_idx] <= 1'b0;
         end
      end
   end

   // Registered voice table and event pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            voices[v] <= '{on: 1'b0, key: KEY_NONE};
         end
         voice_upd <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            voices[v] <= voices_nxt[v];
         end
         voice_upd <= upd_nxt;
         dropped   <= drop_nxt;
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
      assign voice_key[g*KEY_W +: KEY_W] = voices[g].key;
      assign voice_on[g]                 = voices[g].on;
   end

endmodule
